dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//   Shares the single data memory between two requesters: port 0 (CPU load/store unit)
//   and port 1 (secondary master: debug/DMA loader). Arbitrates, latches the winning
//   request, drives the memory for exactly one cycle, returns read data with a one-cycle
//   ack pulse, and rejects misaligned or out-of-range accesses.
// PARAMETERS
//   MEM_BYTES  16384  byte size of data memory; any access with addr >= MEM_BYTES is an error
//   AW         32     address width
//   DW         32     data width (fixed 32; CTL encodes 0=byte, 1=half, 2=word, 3=illegal)
// PORTS
//   clk        in   1    clock, all state on posedge
//   clr        in   1    asynchronous active-high reset
//   req        in   2    per-port request; held high until ack seen
//   we         in   2    per-port write enable (sampled with req)
//   addr0/1    in   AW   per-port byte address
//   wd0/1      in   DW   per-port write data
//   ctl0/1     in   2    per-port access size
//   ack        out  2    one-cycle completion pulse, one-hot
//   err        out  1    valid with ack: access rejected (no memory write performed)
//   rdata      out  DW   registered read data, valid with ack, held until next ack
//   mem_addr   out  AW   to memory addr
//   mem_wd     out  DW   to memory WD
//   mem_ctl    out  2    to memory CTL
//   mem_we     out  1    to memory WE
//   mem_rd     in   DW   combinational read data from memory
// BEHAVIOUR
//   - FSM: IDLE -> ACCESS -> RESP -> IDLE. Fixed latency: req sampled in IDLE at edge N,
//     memory driven during cycle N+1, ack high during cycle N+2, IDLE again N+3.
//   - IDLE: if req!=0 pick winner, latch addr/wd/ctl/we/port, compute err, go ACCESS.
//   - Error: ctl==3; ctl==1 with addr[0]; ctl==2 with addr[1:0]!=0; addr>=MEM_BYTES.
//   - ACCESS: mem_addr/mem_wd/mem_ctl from latch; mem_we = latched we & ~err, this cycle
//     only; rdata <= err ? 0 : mem_rd at end of cycle; go RESP.
//   - RESP: ack[port]=1, err=latched err; go IDLE. Requester sees ack at the edge ending
//     RESP and must drop or replace req before IDLE samples it.
//   - mem_we is 0 in every state except ACCESS; mem_addr/mem_wd/mem_ctl hold latched values.
//   - Both req high in IDLE: arbitration per CONFIGURATION; loser waits, not dropped.
//   - req deasserted while ACCESS/RESP: transaction still completes, ack still pulses.
//   - clr at any time: state=IDLE immediately; ack=0, err=0, mem_we=0, rdata=0,
//     mem_addr=0, mem_wd=0, mem_ctl=0, last-winner=port1 (so port0 wins first RR tie).
//     A write in ACCESS when clr rises is abandoned (mem_we drops asynchronously).
//   - Throughput: max one access per 3 cycles; no back-to-back bypass.
// CONFIGURATION
//   DM_ARB_RR_EN defined: round-robin on ties; winner = port not granted last; last-winner
//     updated only on grant (IDLE->ACCESS).
//   DM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties; port 1 can starve
//     under continuous port-0 traffic (accepted for CPU-first systems).
//   Single-requester behaviour identical in both builds.
// TESTING
//   1. Reset: clr pulse mid-ACCESS with we=1 -> mem_we falls same cycle, ack/err/rdata=0,
//      FSM IDLE; memory word unchanged.
//   2. Port0 word write addr=0x10 wd=0xDEADBEEF ctl=2, then read -> ack[0] two cycles after
//      each sampling edge, rdata=0xDEADBEEF, err=0.
//   3. Port1 byte write addr=0x13 wd=0xAA ctl=0 over 0x11223344 -> read returns 0xAA223344.
//   4. Misaligned: ctl=2 addr=0x12, ctl=1 addr=0x21, ctl=3, addr=MEM_BYTES -> ack with err=1,
//      mem_we never high, rdata=0.
//   5. Both req held for 6 transactions: RR build -> ack order 0,1,0,1,0,1; fixed build
//      -> 0,0,0,... port1 served only after req0 drops.
//   6. Port0 drops req during ACCESS -> ack[0] still pulses once; next IDLE grants port1.

Source files
------------

// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter_if
// Brief    : Requester and memory-side signal bundle for the data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic [1:0]    ctl0;
    logic [1:0]    ctl1;
    logic [1:0]    ack;
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [1:0]    mem_ctl;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  req, we, addr0, addr1, wd0, wd1, ctl0, ctl1, mem_rd,
        output ack, err, rdata, mem_addr, mem_wd, mem_ctl, mem_we
    );

    modport master (
        output req, we, addr0, addr1, wd0, wd1, ctl0, ctl1, mem_rd,
        input  ack, err, rdata, mem_addr, mem_wd, mem_ctl, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Brief    : Two-port data memory arbiter, fixed 3-cycle access with error check.
//            DM_ARB_RR_EN defined selects round-robin ties, else port 0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int MEM_BYTES = 16384,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  wire logic   clk,
    input  wire logic   clr,
    dm_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [AW-1:0] c_MEM_LIMIT = AW'(MEM_BYTES);

    state_t        state_q, state_d;
    logic          port_q,  port_d;
    logic          we_q,    we_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wd_q,    wd_d;
    logic [1:0]    ctl_q,   ctl_d;
    logic          err_q,   err_d;
    logic [DW-1:0] rdata_q, rdata_d;
`ifdef DM_ARB_RR_EN
    logic          last_q,  last_d;
`endif

    logic          w_grant;

    function automatic logic access_err(input logic [AW-1:0] a, input logic [1:0] c);
        return (c == 2'd3) ||
               (c == 2'd1 && a[0]) ||
               (c == 2'd2 && a[1:0] != 2'b00) ||
               (a >= c_MEM_LIMIT);
    endfunction

`ifdef DM_ARB_RR_EN
    // On a tie the port that did not win the previous grant goes first.
    assign w_grant = (&bus.req) ? ~last_q : bus.req[1];
`else
    assign w_grant = bus.req[1] & ~bus.req[0];
`endif

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        ctl_d   = ctl_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef DM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    port_d  = w_grant;
                    we_d    = w_grant ? bus.we[1] : bus.we[0];
                    addr_d  = w_grant ? bus.addr1 : bus.addr0;
                    wd_d    = w_grant ? bus.wd1   : bus.wd0;
                    ctl_d   = w_grant ? bus.ctl1  : bus.ctl0;
                    err_d   = access_err(w_grant ? bus.addr1 : bus.addr0,
                                         w_grant ? bus.ctl1  : bus.ctl0);
`ifdef DM_ARB_RR_EN
                    last_d  = w_grant;
`endif
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rdata_d = err_q ? '0 : bus.mem_rd;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            ctl_q   <= 2'd0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef DM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            ctl_q   <= ctl_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef DM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Write strobe is decoded from state so a reset mid-access kills it immediately.
    assign bus.mem_we   = (state_q == S_ACCESS) & we_q & ~err_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wd   = wd_q;
    assign bus.mem_ctl  = ctl_q;
    assign bus.ack      = (state_q == S_RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.err      = (state_q == S_RESP) & err_q;
    assign bus.rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Brief    : Scoreboard bench for dm_arbiter with a byte-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int MEM_BYTES = 16384;

    typedef struct {
        int          port;
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        mem_init;
    logic        skip_we;
    logic        q0, q1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  c0, c1;

    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    int          ref_last;
    exp_t        sb[$];
    exp_t        e_mon;
    int          checks = 0;
    int          errors = 0;

    logic        ct_w [2][3];
    logic [31:0] ct_a [2][3];
    logic [31:0] ct_d [2][3];

    dm_arbiter_if #(.AW(32), .DW(32)) bus ();

    dm_arbiter #(.MEM_BYTES(MEM_BYTES), .AW(32), .DW(32)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.req   = {q1, q0};
    assign bus.we    = {w1, w0};
    assign bus.addr0 = a0;
    assign bus.addr1 = a1;
    assign bus.wd0   = d0;
    assign bus.wd1   = d1;
    assign bus.ctl0  = c0;
    assign bus.ctl1  = c1;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) ^ (i >> 8));
    endfunction

    // Memory: little-endian bytes, returns the aligned word, stores size bytes from wd.
    assign bus.mem_rd = {mem[{bus.mem_addr[13:2], 2'd3}], mem[{bus.mem_addr[13:2], 2'd2}],
                         mem[{bus.mem_addr[13:2], 2'd1}], mem[{bus.mem_addr[13:2], 2'd0}]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= pat(i);
        end else if (bus.mem_we) begin
            for (int k = 0; k < (1 << bus.mem_ctl); k++)
                mem[int'(bus.mem_addr[13:0]) + k] <= bus.mem_wd[8*k +: 8];
        end
    end

    task automatic model_push(input int p, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] c);
        exp_t e;
        int   base;
        e.port  = p;
        e.we    = w;
        e.err   = (c == 3) || (c == 1 && a % 2 != 0) || (c == 2 && a % 4 != 0) ||
                  (a >= MEM_BYTES);
        e.rdata = 32'h0;
        if (!e.err) begin
            base    = int'(a) - int'(a % 4);
            e.rdata = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
            if (w) begin
                for (int k = 0; k < (1 << c); k++) ref_mem[int'(a) + k] = d[8*k +: 8];
            end
        end
        ref_last = p;
        sb.push_back(e);
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] c);
        if (p == 0) begin
            q0 = r; w0 = w; a0 = a; d0 = d; c0 = c;
        end else begin
            q1 = r; w1 = w; a1 = a; d1 = d; c1 = c;
        end
    endtask

    task automatic do_single(input int p, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] c, output logic [31:0] rd);
        int n;
        @(negedge clk);
        model_push(p, w, a, d, c);
        drive(p, 1'b1, w, a, d, c);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ack[p] && n < 20);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL latency port%0d got %0d cycles want 2", p, n);
        end
        rd = bus.rdata;
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    endtask

    task automatic drv(input int p);
        int n;
        for (int j = 0; j < 3; j++) begin
            drive(p, 1'b1, ct_w[p][j], ct_a[p][j], ct_d[p][j], 2'd2);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.ack[p] && n < 40);
            checks++;
            if (!bus.ack[p]) begin
                errors++;
                $display("FAIL contention_timeout port%0d txn %0d got no ack want ack", p, j);
            end
        end
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every ack retires the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!clr) begin
            if (bus.ack != 2'b00) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected got ack=%b want none", bus.ack);
                end else begin
                    e_mon = sb.pop_front();
                    checks++;
                    if (bus.ack != (e_mon.port == 1 ? 2'b10 : 2'b01)) begin
                        errors++;
                        $display("FAIL ack_port got ack=%b want port%0d", bus.ack, e_mon.port);
                    end
                    checks++;
                    if (bus.err !== e_mon.err) begin
                        errors++;
                        $display("FAIL err got %b want %b", bus.err, e_mon.err);
                    end
                    checks++;
                    if (bus.rdata !== e_mon.rdata) begin
                        errors++;
                        $display("FAIL rdata got %h want %h", bus.rdata, e_mon.rdata);
                    end
                end
            end
            if (bus.mem_we && !skip_we) begin
                checks++;
                if (sb.size() == 0 || !sb[0].we || sb[0].err) begin
                    errors++;
                    $display("FAIL mem_we got 1 want 0 addr=%h", bus.mem_addr);
                end
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int          n;
        int          idx[2];
        int          win;
        int          p;
        logic [1:0]  c;
        logic [31:0] a;

        clr = 1'b1; mem_init = 1'b1; skip_we = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = pat(i);
        ref_last = 1;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wd", bus.mem_wd, 32'h0);
        chk("rst_mem_ctl", 32'(bus.mem_ctl), 32'h0);

        // Word write and readback on port 0.
        do_single(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, rd);
        do_single(0, 1'b0, 32'h10, 32'h0, 2'd2, rd);
        chk("p0_word_read", rd, 32'hDEADBEEF);

        // Byte merge on port 1.
        do_single(1, 1'b1, 32'h10, 32'h11223344, 2'd2, rd);
        do_single(1, 1'b1, 32'h13, 32'h000000AA, 2'd0, rd);
        do_single(1, 1'b0, 32'h10, 32'h0, 2'd2, rd);
        chk("p1_byte_merge", rd, 32'hAA223344);

        // Reset in the middle of a write access.
        @(negedge clk);
        skip_we = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h40, 32'h12345678, 2'd2);
        @(posedge clk);
        #1;
        chk("abort_we_before", 32'(bus.mem_we), 32'h1);
        #1 clr = 1'b1;
        #1;
        chk("abort_we_after", 32'(bus.mem_we), 32'h0);
        chk("abort_ack", 32'(bus.ack), 32'h0);
        chk("abort_err", 32'(bus.err), 32'h0);
        chk("abort_rdata", bus.rdata, 32'h0);
        chk("abort_mem_addr", bus.mem_addr, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        skip_we = 1'b0;
        ref_last = 1;
        do_single(0, 1'b0, 32'h40, 32'h0, 2'd2, rd);

        // Rejected accesses.
        do_single(0, 1'b1, 32'h12, 32'hFFFFFFFF, 2'd2, rd);
        do_single(1, 1'b1, 32'h21, 32'hFFFFFFFF, 2'd1, rd);
        do_single(0, 1'b1, 32'h20, 32'hFFFFFFFF, 2'd3, rd);
        do_single(1, 1'b1, 32'(MEM_BYTES), 32'hFFFFFFFF, 2'd2, rd);
        chk("err_rdata_zero", rd, 32'h0);
        do_single(0, 1'b0, 32'h20, 32'h0, 2'd2, rd);

        // Port 0 withdraws during ACCESS; port 1 takes the next IDLE.
        @(negedge clk);
        model_push(0, 1'b0, 32'h10, 32'h0, 2'd2);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        model_push(1, 1'b0, 32'h14, 32'h0, 2'd2);
        drive(1, 1'b1, 1'b0, 32'h14, 32'h0, 2'd2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ack[1] && n < 20);
        chk("drop_then_p1_latency", 32'(n), 32'd4);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);

        // Both ports held for six transactions; order follows the tie policy.
        for (int pp = 0; pp < 2; pp++) begin
            for (int j = 0; j < 3; j++) begin
                ct_w[pp][j] = 1'($urandom_range(0, 1));
                ct_a[pp][j] = 32'(32'h100 + pp * 32'h20 + j * 4);
                ct_d[pp][j] = $urandom;
            end
        end
        idx = '{0, 0};
        for (int k = 0; k < 6; k++) begin
            if (idx[0] < 3 && idx[1] < 3) begin
`ifdef DM_ARB_RR_EN
                win = 1 - ref_last;
`else
                win = 0;
`endif
            end else begin
                win = (idx[0] < 3) ? 0 : 1;
            end
            model_push(win, ct_w[win][idx[win]], ct_a[win][idx[win]], ct_d[win][idx[win]], 2'd2);
            idx[win]++;
        end
        @(negedge clk);
        fork
            drv(0);
            drv(1);
        join

        // Randomized single-requester traffic, including boundary addresses.
        for (int t = 0; t < 40; t++) begin
            p = int'($urandom_range(0, 1));
            c = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0)
                a = 32'(MEM_BYTES - 4 + int'($urandom_range(0, 8)));
            else
                a = 32'($urandom_range(0, 63));
            do_single(p, 1'($urandom_range(0, 1)), a, $urandom, c, rd);
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
